// File: rtl/gf180mcu_cg_pkg.sv
// gf180mcu_cg_pkg: shared types and helpers for the clock-gate idle controller
package gf180mcu_cg_pkg;
  typedef enum logic [1:0] {OFF = 2'd0, WAKE = 2'd1, ON = 2'd2, DRAIN = 2'd3} cg_state_e;
  localparam int WAKE_LAT_MIN = 1;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return v == max ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/gf180mcu_cg_satcnt.sv
// gf180mcu_cg_satcnt: saturating up-counter with synchronous clear
module gf180mcu_cg_satcnt import gf180mcu_cg_pkg::*; #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RN,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge CLK)
    if (!RN || clr) q <= '0;
    else if (inc) q <= W'(sat_inc(32'(q), 32'({W{1'b1}})));
endmodule

// File: rtl/gf180mcu_cg_idle_ctrl.sv
// gf180mcu_cg_idle_ctrl: auto clock-gating controller driving an ICG enable
module gf180mcu_cg_idle_ctrl import gf180mcu_cg_pkg::*; #(
  parameter int NREQ     = 4,
  parameter int CNT_W    = 8,
  parameter int WAKE_LAT = 2,
  parameter int GCNT_W   = 16
) (
  input  logic              CLK,
  input  logic              RN,
  input  logic [NREQ-1:0]   REQ,
  input  logic              BUSY,
  input  logic              FORCE_ON,
  input  logic [CNT_W-1:0]  IDLE_CYC,
  input  logic              GCNT_CLR,
  output logic              E,
  output logic [NREQ-1:0]   ACK,
  output logic              CLK_ON,
  output logic [GCNT_W-1:0] GATE_CNT
);
  localparam int WL = WAKE_LAT < WAKE_LAT_MIN ? WAKE_LAT_MIN : WAKE_LAT;
  localparam int WW = $clog2(WL + 1);
  cg_state_e state, nxt;
  logic [WW-1:0] wcnt, wcnt_n;
  logic [CNT_W-1:0] icnt, icnt_n;
  logic wake;
  assign wake = |REQ | BUSY | FORCE_ON;
  always_comb begin
    nxt = state;
    wcnt_n = wcnt;
    icnt_n = icnt;
    case (state)
      OFF: if (wake) begin
        nxt = WAKE;
        wcnt_n = WW'(WL - 1);
      end
      WAKE: if (wcnt == '0) nxt = ON;
            else wcnt_n = wcnt - WW'(1);
      ON: if (!wake) begin
        nxt = IDLE_CYC == '0 ? OFF : DRAIN;
        icnt_n = IDLE_CYC - CNT_W'(1);
      end
      DRAIN: if (wake) nxt = ON;
             else if (icnt == '0) nxt = OFF;
             else icnt_n = icnt - CNT_W'(1);
      default: nxt = OFF;
    endcase
  end
  // E is registered from the next state so the ICG sees a clean flop output
  always_ff @(posedge CLK)
    if (!RN) begin
      state <= OFF;
      E <= 1'b0;
      wcnt <= '0;
      icnt <= '0;
    end else begin
      state <= nxt;
      E <= nxt != OFF;
      wcnt <= wcnt_n;
      icnt <= icnt_n;
    end
  assign ACK = REQ & {NREQ{state == ON}};
  assign CLK_ON = state == ON || state == DRAIN;
  gf180mcu_cg_satcnt #(.W(GCNT_W)) u_gcnt (
    .CLK (CLK),
    .RN  (RN),
    .clr (GCNT_CLR),
    .inc (state == OFF),
    .q   (GATE_CNT)
  );
endmodule
